// File: rtl/bus_drv_pkg.sv
// Shared types for the column multicaster bus driver: packet payload and tag width.
package bus_drv_pkg;

   localparam int unsigned DATA_WIDTH = 16;
   localparam int unsigned NUM_COL    = 4;
   localparam int unsigned TW         = $clog2(NUM_COL) + 1;
   localparam int unsigned PSUM_W     = 2 * DATA_WIDTH;

   typedef struct packed {
      logic [TW-1:0]         tag;
      logic [DATA_WIDTH-1:0] ifmap;
      logic [DATA_WIDTH-1:0] fltr;
      logic [PSUM_W-1:0]     psum;
   } packet_t;

endpackage

// File: rtl/bus_if.sv
// Column multicaster bus: the driver owns the B2M side, multicasters own the M2B side.
interface BUS_IF #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_COL    = 4
);
   localparam int unsigned TW = $clog2(NUM_COL) + 1;

   logic [DATA_WIDTH-1:0]   ifmap_data_B2M;
   logic [DATA_WIDTH-1:0]   fltr_data_B2M;
   logic [2*DATA_WIDTH-1:0] psum_data_B2M;
   logic                    CASTER_EN;
   logic                    READY;
   logic [TW-1:0]           ID;
   logic [7:0]              kernel_size;
   logic [2*DATA_WIDTH-1:0] psum_data_M2B;
   logic                    VALID;
   logic                    flush;
   logic                    flush_BUSY;

   modport BUS_port (
      output ifmap_data_B2M, fltr_data_B2M, psum_data_B2M,
      output CASTER_EN, READY, ID, kernel_size,
      input  psum_data_M2B, VALID, flush, flush_BUSY
   );

   modport M_port (
      input  ifmap_data_B2M, fltr_data_B2M, psum_data_B2M,
      input  CASTER_EN, READY, ID, kernel_size,
      output psum_data_M2B, VALID, flush, flush_BUSY
   );
endinterface

// File: rtl/bus_pkt_fifo.sv
// Synchronous packet FIFO; clear has priority over push/pop and drops all contents.
module bus_pkt_fifo
   import bus_drv_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  packet_t                    wdata,
   output packet_t                    head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   packet_t         mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   cnt;
   logic            do_push;
   logic            do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign count   = cnt;
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointer and occupancy tracking; a simultaneous push and pop leaves cnt unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/mc_bus_driver.sv
// Initiator end of the column multicaster bus: queues tagged packets, broadcasts one per
// cycle with a CASTER_EN strobe, returns psums upstream and holds the kernel_size register.
module mc_bus_driver
   import bus_drv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_COL    = 4,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [$clog2(NUM_COL):0]  in_tag,
   input  logic [DATA_WIDTH-1:0]     in_ifmap,
   input  logic [DATA_WIDTH-1:0]     in_fltr,
   input  logic [2*DATA_WIDTH-1:0]   in_psum,
   input  logic                      cfg_we,
   input  logic [7:0]                cfg_kernel_size,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*DATA_WIDTH-1:0]   out_psum,
   output logic [15:0]               issue_cnt,
   BUS_IF.BUS_port                   bus
);
   localparam int unsigned IDW = $clog2(NUM_COL) + 1;
   localparam int unsigned PW  = 2 * DATA_WIDTH;
   localparam int unsigned CW  = $clog2(DEPTH) + 1;

   packet_t                pkt_in;
   packet_t                pkt_head;
   logic [CW-1:0]          fifo_count;
   logic                   fifo_empty;
   logic                   fifo_full;
   logic                   push_c;
   logic                   issue_c;
   logic                   ret_ready_c;

   logic                   caster_en_q;
   logic [IDW-1:0]         id_q;
   logic [DATA_WIDTH-1:0]  ifmap_q;
   logic [DATA_WIDTH-1:0]  fltr_q;
   logic [PW-1:0]          psum_q;
   logic [7:0]             kernel_size_q;

   assign pkt_in = '{tag: in_tag, ifmap: in_ifmap, fltr: in_fltr, psum: in_psum};

   // Space is judged on the registered count only, so a same-cycle pop never frees a slot.
   assign in_ready    = (fifo_count != CW'(DEPTH)) && !bus.flush;
   assign push_c      = in_valid && in_ready && !fifo_full;
   assign issue_c     = !fifo_empty && !bus.flush && !bus.flush_BUSY;
   assign ret_ready_c = !out_valid || out_ready;

   bus_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_c),
      .pop   (issue_c),
      .clear (bus.flush),
      .wdata (pkt_in),
      .head  (pkt_head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // Broadcast registers: ID and data hold between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         caster_en_q <= 1'b0;
         id_q        <= '0;
         ifmap_q     <= '0;
         fltr_q      <= '0;
         psum_q      <= '0;
         issue_cnt   <= '0;
      end else begin
         caster_en_q <= issue_c;
         if (issue_c) begin
            id_q      <= pkt_head.tag;
            ifmap_q   <= pkt_head.ifmap;
            fltr_q    <= pkt_head.fltr;
            psum_q    <= pkt_head.psum;
            issue_cnt <= issue_cnt + 16'(1);
         end
      end
   end

   // Return path: single skid-free holding register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_psum  <= '0;
      end else if (bus.VALID && ret_ready_c) begin
         out_valid <= 1'b1;
         out_psum  <= bus.psum_data_M2B;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      kernel_size_q <= '0;
      else if (cfg_we) kernel_size_q <= cfg_kernel_size;
   end

   assign bus.CASTER_EN      = caster_en_q;
   assign bus.ID             = id_q;
   assign bus.ifmap_data_B2M = ifmap_q;
   assign bus.fltr_data_B2M  = fltr_q;
   assign bus.psum_data_B2M  = psum_q;
   assign bus.kernel_size    = kernel_size_q;
   assign bus.READY          = ret_ready_c;

endmodule

// File: tb/tb_mc_bus_driver.sv
// Scoreboard bench for mc_bus_driver: stimulus pushes expectations, monitors pop and compare.
module tb_mc_bus_driver;
   import bus_drv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_tag;
   logic [15:0] in_ifmap;
   logic [15:0] in_fltr;
   logic [31:0] in_psum;
   logic        cfg_we;
   logic [7:0]  cfg_kernel_size;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_psum;
   logic [15:0] issue_cnt;

   BUS_IF #(.DATA_WIDTH(16), .NUM_COL(4)) bus_i ();

   mc_bus_driver #(.DATA_WIDTH(16), .NUM_COL(4), .DEPTH(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_tag          (in_tag),
      .in_ifmap        (in_ifmap),
      .in_fltr         (in_fltr),
      .in_psum         (in_psum),
      .cfg_we          (cfg_we),
      .cfg_kernel_size (cfg_kernel_size),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_psum        (out_psum),
      .issue_cnt       (issue_cnt),
      .bus             (bus_i)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          st_n    = 0;
   int          st_first = 0;
   int          st_last  = 0;
   packet_t     exp_q [$];
   logic [31:0] ret_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Bus monitor: every strobe must match the oldest outstanding packet.
   initial forever begin
      packet_t p;
      @(negedge clk);
      if (rst_n && bus_i.CASTER_EN === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_issue", 64'(bus_i.CASTER_EN), 64'd0);
         end else begin
            p = exp_q.pop_front();
            check("issue_id",    64'(bus_i.ID),             64'(p.tag));
            check("issue_ifmap", 64'(bus_i.ifmap_data_B2M), 64'(p.ifmap));
            check("issue_fltr",  64'(bus_i.fltr_data_B2M),  64'(p.fltr));
            check("issue_psum",  64'(bus_i.psum_data_B2M),  64'(p.psum));
         end
         if (st_n == 0) st_first = cyc;
         st_last = cyc;
         st_n++;
      end
   end

   // Return monitor: compare on each upstream handshake.
   initial forever begin
      @(negedge clk);
      if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (ret_q.size() == 0) check("spurious_ret", 64'(out_valid), 64'd0);
         else                   check("ret_psum", 64'(out_psum), 64'(ret_q.pop_front()));
      end
   end

   task automatic push(input logic [2:0] tag, input logic [15:0] ifm, input logic [15:0] flt,
                       input logic [31:0] ps);
      bit done = 1'b0;
      in_valid = 1'b1;
      in_tag   = tag;
      in_ifmap = ifm;
      in_fltr  = flt;
      in_psum  = ps;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back('{tag: tag, ifmap: ifm, fltr: flt, psum: ps});
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("push_accept", 64'(done), 64'd1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_caster_en"},   64'(bus_i.CASTER_EN),      64'd0);
      check({tag, "_id"},          64'(bus_i.ID),             64'd0);
      check({tag, "_ifmap"},       64'(bus_i.ifmap_data_B2M), 64'd0);
      check({tag, "_fltr"},        64'(bus_i.fltr_data_B2M),  64'd0);
      check({tag, "_psum_b2m"},    64'(bus_i.psum_data_B2M),  64'd0);
      check({tag, "_kernel_size"}, 64'(bus_i.kernel_size),    64'd0);
      check({tag, "_out_valid"},   64'(out_valid),            64'd0);
      check({tag, "_out_psum"},    64'(out_psum),             64'd0);
      check({tag, "_issue_cnt"},   64'(issue_cnt),            64'd0);
      check({tag, "_in_ready"},    64'(in_ready),             64'd1);
      check({tag, "_bus_ready"},   64'(bus_i.READY),          64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_tag = '0; in_ifmap = '0; in_fltr = '0; in_psum = '0;
      cfg_we = 1'b0; cfg_kernel_size = '0; out_ready = 1'b1;
      bus_i.VALID = 1'b0; bus_i.psum_data_M2B = '0;
      bus_i.flush = 1'b0; bus_i.flush_BUSY = 1'b0;

      repeat (3) @(posedge clk);
      #1 check_zero("rst");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Single packet: strobe one cycle after the accepting edge, exactly one cycle wide.
      push(3'd2, 16'h0011, 16'h0022, 32'h0000_0033);
      @(negedge clk) check("lat_pre",      64'(bus_i.CASTER_EN), 64'd0);
      @(negedge clk) check("lat_strobe",   64'(bus_i.CASTER_EN), 64'd1);
      @(negedge clk) check("strobe_width", 64'(bus_i.CASTER_EN), 64'd0);
      check("cnt_single", 64'(issue_cnt), 64'd1);

      // Fill while stalled, then drain: fifth packet slips in behind as space frees.
      @(posedge clk); #1;
      bus_i.flush_BUSY = 1'b1;
      for (int i = 0; i < 4; i++)
         push(3'(i), 16'h0100 + 16'(i), 16'h0200 + 16'(i), 32'h0000_0300 + 32'(i));
      @(negedge clk) check("full_in_ready", 64'(in_ready), 64'd0);
      st_n = 0;
      fork
         push(3'd4, 16'h0104, 16'h0204, 32'h0000_0304);
         begin
            @(posedge clk); #1;
            bus_i.flush_BUSY = 1'b0;
         end
      join
      repeat (8) @(posedge clk);
      #1;
      check("fill_issues", 64'(st_n), 64'd5);
      check("fill_span",   64'(st_last - st_first), 64'd4);
      check("cnt_fill",    64'(issue_cnt), 64'd6);

      // Three-cycle stall in the middle of a six-packet stream.
      st_n = 0;
      fork
         for (int i = 0; i < 6; i++)
            push(3'(i), 16'h0A00 + 16'(i), 16'h0B00 + 16'(i), 32'hC000_0000 + 32'(i));
         begin
            repeat (3) @(posedge clk);
            #1 bus_i.flush_BUSY = 1'b1;
            repeat (3) @(posedge clk);
            #1 bus_i.flush_BUSY = 1'b0;
         end
      join
      repeat (8) @(posedge clk);
      #1;
      check("stall_issues", 64'(st_n), 64'd6);
      check("stall_span",   64'(st_last - st_first), 64'd8);
      check("cnt_stall",    64'(issue_cnt), 64'd12);

      // Flush with three packets queued: all are dropped.
      bus_i.flush_BUSY = 1'b1;
      for (int i = 0; i < 3; i++)
         push(3'(i + 1), 16'h0E00 + 16'(i), 16'h0F00 + 16'(i), 32'hDEAD_0000 + 32'(i));
      bus_i.flush = 1'b1;
      exp_q.delete();
      @(negedge clk) check("flush_in_ready0", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      @(negedge clk) check("flush_in_ready1", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      bus_i.flush = 1'b0;
      bus_i.flush_BUSY = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("flush_dropped",   64'(issue_cnt), 64'd12);
      check("flush_ready_aft", 64'(in_ready),  64'd1);
      push(3'd3, 16'h0ABC, 16'h0DEF, 32'h1234_5678);
      repeat (3) @(posedge clk);
      #1 check("cnt_post_flush", 64'(issue_cnt), 64'd13);

      // Return path under backpressure.
      out_ready = 1'b0;
      bus_i.VALID = 1'b1;
      bus_i.psum_data_M2B = 32'h0000_000A;
      @(negedge clk);
      check("ret_ready_idle", 64'(bus_i.READY), 64'd1);
      ret_q.push_back(32'h0000_000A);
      @(posedge clk); #1;
      bus_i.psum_data_M2B = 32'h0000_000B;
      @(negedge clk);
      check("ret_ready_bp",  64'(bus_i.READY), 64'd0);
      check("ret_valid",     64'(out_valid),   64'd1);
      check("ret_first",     64'(out_psum),    64'h0000_000A);
      repeat (2) begin
         @(negedge clk);
         check("ret_hold",      64'(out_psum),    64'h0000_000A);
         check("ret_ready_low", 64'(bus_i.READY), 64'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("ret_ready_rel", 64'(bus_i.READY), 64'd1);
      ret_q.push_back(32'h0000_000B);
      @(posedge clk); #1;
      bus_i.VALID = 1'b0;
      @(negedge clk) check("ret_second", 64'(out_psum), 64'h0000_000B);
      @(posedge clk); #1;
      @(negedge clk) check("ret_clear", 64'(out_valid), 64'd0);

      // Configuration register.
      @(posedge clk); #1;
      cfg_we = 1'b1;
      cfg_kernel_size = 8'd3;
      @(negedge clk) check("cfg_pre", 64'(bus_i.kernel_size), 64'd0);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      check("cfg_load", 64'(bus_i.kernel_size), 64'd3);

      // Asynchronous reset in the middle of traffic.
      bus_i.flush_BUSY = 1'b1;
      push(3'd1, 16'h1111, 16'h2222, 32'h3333_3333);
      push(3'd2, 16'h4444, 16'h5555, 32'h6666_6666);
      out_ready = 1'b0;
      bus_i.VALID = 1'b1;
      bus_i.psum_data_M2B = 32'h0000_000C;
      @(negedge clk) ret_q.push_back(32'h0000_000C);
      @(posedge clk); #1;
      bus_i.VALID = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      exp_q.delete();
      ret_q.delete();
      #1 check_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      bus_i.flush_BUSY = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("midrst_no_issue", 64'(issue_cnt), 64'd0);
      check("midrst_out_vld",  64'(out_valid), 64'd0);

      check("sb_bus_drain", 64'(exp_q.size()), 64'd0);
      check("sb_ret_drain", 64'(ret_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_bus_driver.md
# mc_bus_driver

Bus-side transmitter for the column multicaster bus: the initiator end of `BUS_IF`, driving the `BUS_port` modport. It queues tagged ifmap/filter/psum packets from the X-bus controller, broadcasts them one per cycle with an `ID` that each multicaster matches against its `TAG`, and collects returning partial sums. It also holds the `kernel_size` configuration register. One instance sits per row bus, between the X-bus controller and the multicaster columns.

## Interface
- `DATA_WIDTH`, 16, ifmap/filter word width; psum is `2*DATA_WIDTH`.
- `NUM_COL`, 4, columns on the bus; tag/ID width `TW = $clog2(NUM_COL)+1`.
- `DEPTH`, 4, packet queue depth; power of two, ≥2.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: upstream packet valid.
- `in_ready` out 1: queue can accept a packet.
- `in_tag` in TW: destination column tag.
- `in_ifmap` in DATA_WIDTH: ifmap word.
- `in_fltr` in DATA_WIDTH: filter word.
- `in_psum` in 2*DATA_WIDTH: psum word.
- `cfg_we` in 1: load `cfg_kernel_size`.
- `cfg_kernel_size` in 8: kernel size value.
- `out_valid` out 1: returned psum valid.
- `out_ready` in 1: upstream accepts the returned psum.
- `out_psum` out 2*DATA_WIDTH: returned psum.
- `issue_cnt` out 16: count of packets broadcast; wraps modulo 2^16.
- `bus` `BUS_IF.BUS_port`, `#(DATA_WIDTH, NUM_COL)`: drives `ifmap/fltr/psum_data_B2M`, `CASTER_EN`, `READY`, `ID`, `kernel_size`; samples `psum_data_M2B`, `VALID`, `flush`, `flush_BUSY`.

## Operation
- **Queue.** A packet `{tag, ifmap, fltr, psum}` is pushed when `in_valid && in_ready`. `in_ready = (count < DEPTH) && !bus.flush`, derived from the registered count only; a same-cycle pop does not free space.
- **Issue.** An issue happens on a cycle where `count > 0 && !bus.flush && !bus.flush_BUSY`. On that edge the head packet is popped and the bus output registers load:
  - `CASTER_EN` ← 1
  - `ID` ← tag
  - `*_B2M` ← the packet fields
- **No issue.** `CASTER_EN` ← 0. `ID` and data hold their last value.
- `CASTER_EN` is a one-cycle-per-packet strobe. Multicasters carry no backpressure other than `flush_BUSY`.
- A push and a pop in the same cycle leave `count` unchanged.
- **Flush.** While `bus.flush` is sampled high:
  - pointers and count clear (queued packets are dropped);
  - `CASTER_EN` ← 0;
  - `in_ready` is low.
  - The return path is unaffected.
- **Return path.** `bus.READY = !out_valid || out_ready` (combinational). On `bus.VALID && bus.READY`, `out_psum` ← `psum_data_M2B` and `out_valid` ← 1. Otherwise, `out_valid` clears on `out_ready`.
- **Configuration.** On `cfg_we`, `bus.kernel_size` ← `cfg_kernel_size`.
- **Counter.** `issue_cnt` increments once per issue and wraps 0xFFFF→0.

## Timing
- **Reset values.** All outputs are 0: `CASTER_EN`, `ID`, all `*_B2M`, `kernel_size`, `out_valid`, `out_psum`, `issue_cnt`. Queue count is 0.
  - `in_ready` is therefore 1 after reset (unless `flush` is high).
  - `READY` is 1 after reset.
- **Reset mid-operation.** Asserting `rst_n` low immediately forces these values and drops queued packets.
- **Forward latency.** A packet accepted at edge k into an empty queue makes `CASTER_EN` high after edge k+1.
- **Throughput.** One packet per cycle sustained.
- **Ordering.** Strict FIFO.
- **Full queue.** `in_ready` is low for the cycle after the push that fills the queue.
- **`flush_BUSY` mid-stream.** Issue stalls for exactly the cycles it is high. Packets are retained in order and no data is corrupted.
- **Return latency.** `VALID && READY` at edge k gives `out_valid` high after edge k.
- **Return throughput.** One psum per cycle while `out_ready` stays high.
- **Combinational paths.** The only combinational output is `bus.READY`.

## Structure
- Package `bus_drv_pkg`:
  - `typedef struct packed` packet `{tag, ifmap, fltr, psum}`, parameterised by `localparam`s derived from `DATA_WIDTH` and `NUM_COL`;
  - `TW` helper constant.
- Sub-module `bus_pkt_fifo`: a synchronous FIFO of packets with `push`, `pop`, `clear`, `count`, `empty`, `full`, and the same asynchronous active-low reset.
- Top-level module: issue logic, bus output registers, return register, config register and counter.

## Test plan
- **Reset, then single packet.** Push `tag=2, ifmap=0x0011, fltr=0x0022, psum=0x00000033`. Required: one-cycle `CASTER_EN`, `ID=2`, data matches, `issue_cnt=1`.
- **Fill and drain.** Push 5 back-to-back with `DEPTH=4` while `flush_BUSY=1`. Required: `in_ready` drops after 4 pushes. After `flush_BUSY` falls, tags 0,1,2,3 appear on consecutive cycles.
- **Stall mid-stream.** Raise `flush_BUSY` for 3 cycles mid-stream. Required: exactly 3 idle cycles, no lost or duplicated packet, order preserved.
- **Flush.** `flush=1` with 3 packets queued. Required: no further `CASTER_EN`, `in_ready=0` during flush, queue empty afterwards.
- **Return backpressure.** `VALID=1` with psums 0xA, 0xB while `out_ready=0`. Required: `out_psum=0xA` held and `READY=0`. After `out_ready=1`, 0xB follows.
- **Config and reset mid-stream.** `cfg_we` with 3 gives `kernel_size=3` next cycle. Asserting `rst_n` low mid-stream returns every output to 0.
